// File: rtl/execution_unit.sv
// RV32I integer ALU stage: decodes opcode/funct fields, computes the result
// combinationally and registers it with a valid flag; stall freezes the output.
module execution_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            instruction_type,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [20:0]           immediate,
  input  logic                  system_stall,
  input  logic [DATA_WIDTH-1:0] data_src1,
  input  logic [DATA_WIDTH-1:0] data_src2,
  output logic [DATA_WIDTH-1:0] Execution_Result,
  output logic                  Result_valid
);

  localparam logic [6:0] OpReg = 7'b0110011;
  localparam logic [6:0] OpImm = 7'b0010011;
  localparam logic [6:0] OpLui = 7'b0110111;

  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] imm_sext;
  logic [DATA_WIDTH-1:0] lui_val;
  logic [4:0]            shamt;
  logic                  alt;
  logic [DATA_WIDTH-1:0] result_d, result_q;
  logic                  valid_d, valid_q;

  // Only funct7[5] and immediate[19:0] carry meaning for this unit.
  logic unused_bits;
  assign unused_bits = ^{funct7[6], funct7[4:0], immediate[20]};

  assign imm_sext = {{(DATA_WIDTH-12){immediate[11]}}, immediate[11:0]};
  assign lui_val  = DATA_WIDTH'({immediate[19:0], 12'h000});
  assign op_b     = (instruction_type == OpReg) ? data_src2 : imm_sext;
  assign shamt    = op_b[4:0];
  assign alt      = funct7[5];

  always_comb begin
    result_d = '0;
    valid_d  = 1'b0;
    if (instruction_type == OpLui) begin
      result_d = lui_val;
      valid_d  = 1'b1;
    end else if (instruction_type == OpReg || instruction_type == OpImm) begin
      valid_d = 1'b1;
      unique case (funct3)
        3'b000: begin
          // I-type never subtracts, whatever funct7 happens to hold.
          if (instruction_type == OpReg && alt) result_d = data_src1 - op_b;
          else                                  result_d = data_src1 + op_b;
        end
        3'b001: result_d = data_src1 << shamt;
        3'b010: result_d = {{(DATA_WIDTH-1){1'b0}}, $signed(data_src1) < $signed(op_b)};
        3'b011: result_d = {{(DATA_WIDTH-1){1'b0}}, data_src1 < op_b};
        3'b100: result_d = data_src1 ^ op_b;
        3'b101: begin
          if (alt) result_d = DATA_WIDTH'($signed(data_src1) >>> shamt);
          else     result_d = data_src1 >> shamt;
        end
        3'b110: result_d = data_src1 | op_b;
        3'b111: result_d = data_src1 & op_b;
        default: result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (!system_stall) begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign Execution_Result = result_q;
  assign Result_valid     = valid_q;

endmodule

// File: tb/tb_execution_unit.sv
// Bench for execution_unit: directed vector table, hand-written stall/reset
// sequences, then randomized traffic against a behavioural model.
module tb_execution_unit;

  localparam logic [6:0] OpR = 7'b0110011;
  localparam logic [6:0] OpI = 7'b0010011;
  localparam logic [6:0] OpL = 7'b0110111;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  instruction_type;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [20:0] immediate;
  logic        system_stall;
  logic [31:0] data_src1, data_src2;
  logic [31:0] Execution_Result;
  logic        Result_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execution_unit #(.DATA_WIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .instruction_type (instruction_type),
    .funct3           (funct3),
    .funct7           (funct7),
    .immediate        (immediate),
    .system_stall     (system_stall),
    .data_src1        (data_src1),
    .data_src2        (data_src2),
    .Execution_Result (Execution_Result),
    .Result_valid     (Result_valid)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [20:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_valid;
    string       name;
  } vec_t;

  vec_t vecs[16];

  // Reference: RV32I ALU semantics written straight from the instruction rules.
  function automatic logic [32:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [20:0] imm,
                                        input logic [31:0] a, input logic [31:0] b_reg);
    logic [31:0] b;
    logic [31:0] r;
    int unsigned sh;
    if (op == OpL) return {1'b1, imm[19:0], 12'h000};
    if (op != OpR && op != OpI) return 33'd0;
    b  = (op == OpR) ? b_reg : {{20{imm[11]}}, imm[11:0]};
    sh = int'(b[4:0]);
    case (f3)
      3'd0: r = (op == OpR && f7[5]) ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: r = f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return {1'b1, r};
  endfunction

  task automatic check(input string name, input logic [31:0] exp_res, input logic exp_valid);
    checks++;
    if (Execution_Result !== exp_res || Result_valid !== exp_valid) begin
      errors++;
      $display("FAIL %s: got result=%08h valid=%b, want result=%08h valid=%b",
               name, Execution_Result, Result_valid, exp_res, exp_valid);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [20:0] imm,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    reset = rst; system_stall = stl; instruction_type = op;
    funct3 = f3; funct7 = f7; immediate = imm; data_src1 = a; data_src2 = b;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_res;
  logic        exp_valid;
  logic [32:0] m;

  initial begin
    reset = 1'b1; system_stall = 1'b0; instruction_type = '0; funct3 = '0;
    funct7 = '0; immediate = '0; data_src1 = '0; data_src2 = '0;

    vecs[0]  = '{OpR, 3'd0, 7'h00, 21'h0,     32'h10,       32'h20,       32'h00000030, 1'b1, "add"};
    vecs[1]  = '{OpR, 3'd0, 7'h20, 21'h0,     32'h30,       32'h10,       32'h00000020, 1'b1, "sub"};
    vecs[2]  = '{OpR, 3'd0, 7'h20, 21'h0,     32'h0,        32'h1,        32'hFFFFFFFF, 1'b1, "sub_wrap"};
    vecs[3]  = '{OpR, 3'd7, 7'h00, 21'h0,     32'hFFFFFFF0, 32'h0F0F0F0F, 32'h0F0F0F00, 1'b1, "and"};
    vecs[4]  = '{OpR, 3'd6, 7'h00, 21'h0,     32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b1, "or"};
    vecs[5]  = '{OpR, 3'd4, 7'h00, 21'h0,     32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b1, "xor"};
    vecs[6]  = '{OpR, 3'd5, 7'h20, 21'h0,     32'h80000000, 32'h4,        32'hF8000000, 1'b1, "sra"};
    vecs[7]  = '{OpR, 3'd5, 7'h00, 21'h0,     32'h80000000, 32'h4,        32'h08000000, 1'b1, "srl"};
    vecs[8]  = '{OpR, 3'd2, 7'h00, 21'h0,     32'hFFFFFFFF, 32'h1,        32'h00000001, 1'b1, "slt"};
    vecs[9]  = '{OpR, 3'd3, 7'h00, 21'h0,     32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b1, "sltu"};
    vecs[10] = '{OpI, 3'd0, 7'h20, 21'hFFF,   32'h5,        32'h99,       32'h00000004, 1'b1, "addi"};
    vecs[11] = '{OpI, 3'd5, 7'h20, 21'h404,   32'h80000000, 32'h0,        32'hF8000000, 1'b1, "srai"};
    vecs[12] = '{OpL, 3'd3, 7'h00, 21'h12345, 32'hDEAD,     32'hBEEF,     32'h12345000, 1'b1, "lui"};
    vecs[13] = '{OpR, 3'd1, 7'h00, 21'h0,     32'h1,        32'h21,       32'h00000002, 1'b1, "sll_mask"};
    vecs[14] = '{7'h00, 3'd0, 7'h00, 21'h0,   32'h10,       32'h20,       32'h00000000, 1'b0, "op_zero"};
    vecs[15] = '{7'h63, 3'd0, 7'h00, 21'h0,   32'h10,       32'h20,       32'h00000000, 1'b0, "op_branch"};

    drive(1'b1, 1'b0, OpR, 3'd0, 7'h00, 21'h0, 32'h10, 32'h20);
    check("reset", 32'h0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].imm, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].exp_res, vecs[i].exp_valid);
    end

    // Stall holds the ADD result while the inputs change to a SUB.
    drive(1'b0, 1'b0, OpR, 3'd0, 7'h00, 21'h0, 32'h10, 32'h20);
    check("stall_pre", 32'h30, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, OpR, 3'd0, 7'h20, 21'h0, 32'h50, 32'h8);
      check("stall_hold", 32'h30, 1'b1);
    end
    drive(1'b0, 1'b0, OpR, 3'd0, 7'h20, 21'h0, 32'h50, 32'h8);
    check("stall_release", 32'h48, 1'b1);

    // Reset wins over stall and discards the in-flight value.
    drive(1'b1, 1'b1, OpR, 3'd0, 7'h00, 21'h0, 32'h1, 32'h1);
    check("reset_over_stall", 32'h0, 1'b0);
    drive(1'b0, 1'b1, OpR, 3'd0, 7'h00, 21'h0, 32'h1, 32'h1);
    check("stall_after_reset", 32'h0, 1'b0);

    exp_res = 32'h0; exp_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic        rst, stl;
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      logic [20:0] imm;
      logic [31:0] a, b;
      rst = ($urandom_range(0, 29) == 0);
      stl = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 4))
        0, 1:    op = OpR;
        2:       op = OpI;
        3:       op = OpL;
        default: op = 7'($urandom);
      endcase
      f3  = 3'($urandom);
      f7  = 7'($urandom);
      imm = 21'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? 32'h80000000 | 32'($urandom_range(0, 3)) : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (rst) begin
        exp_res = 32'h0; exp_valid = 1'b0;
      end else if (!stl) begin
        m = model(op, f3, f7, imm, a, b);
        exp_res = m[31:0]; exp_valid = m[32];
      end
      drive(rst, stl, op, f3, f7, imm, a, b);
      check("random", exp_res, exp_valid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execution_unit.md
# execution_unit

Single-cycle-latency integer execution unit for the RV32I core pipeline, sitting between decode/register-read and writeback. Each cycle it takes the decoded opcode, funct3/funct7, immediate and two source operands, computes the RV32I ALU result, and registers it with a valid flag. A pipeline-wide stall freezes the output register.

## Interface
- `DATA_WIDTH`, default 32: operand/result width; all arithmetic rules below assume 32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `instruction_type` input 7: RV32I opcode field (inst[6:0]).
- `funct3` input 3: inst[14:12].
- `funct7` input 7: inst[31:25]; only bit 5 is decoded.
- `immediate` input 21: decoded immediate, right-justified; I-type uses [11:0], U-type uses [19:0].
- `system_stall` input 1: when high, output register holds its value.
- `data_src1` input DATA_WIDTH: rs1 value.
- `data_src2` input DATA_WIDTH: rs2 value.
- `Execution_Result` output DATA_WIDTH: registered result.
- `Result_valid` output 1: registered; high when `Execution_Result` holds a result for a supported opcode.

## Operation
- Combinational compute, one output register.
- Operand B: `data_src2` for R-type (0110011); sign-extended `immediate[11:0]` for I-type ALU (0010011).
- funct3 decode (R and I):
  - 000: ADD; SUB only for R-type with funct7[5]=1. I-type 000 is always ADDI.
  - 001: SLL, shift amount = B[4:0].
  - 010: SLT, signed compare, result 1 or 0.
  - 011: SLTU, unsigned compare, result 1 or 0.
  - 100: XOR.
  - 101: SRL if funct7[5]=0, SRA (arithmetic, sign-filling) if funct7[5]=1; shift amount = B[4:0] (for I-type, `immediate[4:0]`).
  - 110: OR.
  - 111: AND.
- LUI (0110111): result = {immediate[19:0], 12'b0}; source operands are ignored.
- Add/sub wrap modulo 2^32; no overflow flag.
- Any other opcode, including 0000000: next result = 0 and next valid = 0.
- funct7 bits other than bit 5 are ignored; there is no illegal-instruction detection.

## Timing
- Reset, checked on the rising edge, has top priority and overrides stall: `Execution_Result` = 0, `Result_valid` = 0.
- Normal operation: inputs are sampled on the rising edge, and the result and valid appear after that edge. Latency is 1 cycle, and a new operation can be accepted every cycle.
- `system_stall`=1 at an edge (and reset=0): both outputs hold their previous values and the inputs are ignored. Throughput resumes on the first unstalled edge.
- Reset asserted mid-stream: the in-flight result is discarded and the outputs read 0/0 after that edge.
- No input handshake; upstream must hold or invalidate inputs during stall.

## Test plan
- Reset 1 for one edge, then R-type ADD, funct7=0000000, src1=0x10, src2=0x20 → after next edge Result=0x00000030, valid=1; during reset Result=0, valid=0.
- R-type SUB, funct7=0100000, 0x30-0x10 → 0x00000020; then 0x0-0x1 → 0xFFFFFFFF (wrap).
- R-type logic: AND 0xFFFFFFF0 & 0x0F0F0F0F → 0x0F0F0F00; OR 0xF0F0F0F0 | 0x0F0F0F0F → 0xFFFFFFFF; XOR 0xAAAAAAAA ^ 0x55555555 → 0xFFFFFFFF.
- Shifts and compares, all R-type:
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SRL 0x80000000 by 4 → 0x08000000.
  - SLT 0xFFFFFFFF vs 1 → 1.
  - SLTU 0xFFFFFFFF vs 1 → 0.
- Immediate forms: ADDI src1=5, immediate=0xFFF → 0x00000004; SRAI 0x80000000 with immediate[4:0]=4 and funct7[5]=1 → 0xF8000000; LUI immediate=0x12345 → 0x12345000.
- Stall and unsupported opcode:
  - After ADD → 0x30, raise `system_stall` and change the inputs to a SUB; outputs hold 0x30/valid=1 for every stalled edge, and the SUB result appears one edge after the stall drops.
  - Opcode 0000000 → Result=0, valid=0.
